pulse_ctrl_axil_slave: RTL and testbench

AXI4-Lite responder for the pulse controller: register file plus pulse-train engine driving one electropyrotechnic firing output. Sits behind the interconnect, answering the master VIP and PS master with single-beat reads and writes. Software programs width, count and gap, then triggers a train. The engine drives pulse_out and reports status.

---
 rtl/pulse_ctrl_axil_slave_if.sv | 50 +++++
 rtl/pulse_ctrl_axil_slave.sv | 270 +++++++++++++++++++++++++++
 tb/tb_pulse_ctrl_axil_slave.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_ctrl_axil_slave_if.sv
// AXI4-Lite bundle for the pulse controller register port.
// slave: responder side; master: requester side (VIP/PS/bench).
interface pulse_ctrl_axil_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/pulse_ctrl_axil_slave.sv
// Pulse controller: AXI4-Lite register file + pulse-train engine.
// Ports: ACLK, ARESET (sync, high), s_axi (slave), fault_in, pulse_out, busy.
module pulse_ctrl_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  pulse_ctrl_axil_slave_if.slave s_axi,
  input  logic                   fault_in,
  output logic                   pulse_out,
  output logic                   busy
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = AW - 2;

  typedef logic [DW-1:0] word_t;
  typedef logic [IW-1:0] idx_t;

  localparam idx_t A_CTRL   = idx_t'(0);
  localparam idx_t A_WIDTH  = idx_t'(1);
  localparam idx_t A_COUNT  = idx_t'(2);
  localparam idx_t A_GAP    = idx_t'(3);
  localparam idx_t A_STATUS = idx_t'(4);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } state_t;

  function automatic word_t apply_strb(
    input word_t          old_v,
    input word_t          new_v,
    input logic [SW-1:0]  strb
  );
    word_t r;
    r = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  function automatic word_t less_one(input word_t v);
    return (v == '0) ? '0 : v - word_t'(1);
  endfunction

  // ---------------- write channel ----------------
  logic  aw_rdy_q, w_rdy_q, b_vld_q;
  logic  wr_en;
  idx_t  wr_idx;
  word_t wdata;
  logic  [SW-1:0] wstrb;

  assign wr_idx = s_axi.S_AXI_AWADDR[AW-1:2];
  assign wdata  = s_axi.S_AXI_WDATA;
  assign wstrb  = s_axi.S_AXI_WSTRB;
  assign wr_en  = aw_rdy_q & w_rdy_q
                & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_rdy_q <= 1'b0;
      w_rdy_q  <= 1'b0;
      b_vld_q  <= 1'b0;
    end else begin
      if (!aw_rdy_q && !w_rdy_q && !b_vld_q &&
          s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
        aw_rdy_q <= 1'b1;
        w_rdy_q  <= 1'b1;
      end else begin
        aw_rdy_q <= 1'b0;
        w_rdy_q  <= 1'b0;
      end
      if (wr_en)
        b_vld_q <= 1'b1;
      else if (s_axi.S_AXI_BREADY)
        b_vld_q <= 1'b0;
    end
  end

  assign s_axi.S_AXI_AWREADY = aw_rdy_q;
  assign s_axi.S_AXI_WREADY  = w_rdy_q;
  assign s_axi.S_AXI_BVALID  = b_vld_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;

  // ---------------- register file ----------------
  word_t ctrl_q, width_q, count_q, gap_q;
  logic  done_q, fault_q;

  logic wr_ctrl, wr_stat, b0;
  logic fire, en_now, abort;

  assign b0      = wstrb[0];
  assign wr_ctrl = wr_en && (wr_idx == A_CTRL);
  assign wr_stat = wr_en && (wr_idx == A_STATUS);
  assign fire    = wr_ctrl & b0 & wdata[1];
  // EN seen by the engine includes a value written this cycle
  assign en_now  = (wr_ctrl & b0) ? wdata[0] : ctrl_q[0];
  assign abort   = wr_ctrl & b0 & ~wdata[0];

  // ---------------- engine ----------------
  state_t state_q, state_d;
  word_t  cnt_q, cnt_d;
  word_t  rem_q, rem_d;
  word_t  wk_w_q, wk_w_d;
  word_t  wk_g_q, wk_g_d;
  logic   set_done;
  logic   pulse_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    wk_w_d   = wk_w_q;
    wk_g_d   = wk_g_q;
    set_done = 1'b0;
    if (fault_in) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fire && en_now) begin
            if (count_q == '0) begin
              set_done = 1'b1;
            end else begin
              state_d = ON;
              wk_w_d  = width_q;
              wk_g_d  = gap_q;
              rem_d   = count_q;
              cnt_d   = less_one(width_q);
            end
          end
        end
        ON: begin
          if (abort) begin
            state_d = IDLE;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - word_t'(1);
          end else begin
            rem_d = rem_q - word_t'(1);
            if (rem_q == word_t'(1)) begin
              state_d  = IDLE;
              set_done = 1'b1;
            end else if (wk_g_q == '0) begin
              cnt_d = less_one(wk_w_q);
            end else begin
              state_d = OFF;
              cnt_d   = wk_g_q - word_t'(1);
            end
          end
        end
        OFF: begin
          if (abort) begin
            state_d = IDLE;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - word_t'(1);
          end else begin
            state_d = ON;
            cnt_d   = less_one(wk_w_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      wk_w_q  <= '0;
      wk_g_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      wk_w_q  <= wk_w_d;
      wk_g_q  <= wk_g_d;
      pulse_q <= (state_d == ON);
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_q  <= '0;
      width_q <= '0;
      count_q <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      // FIRE is a strobe, never stored
      if (wr_ctrl)
        ctrl_q <= apply_strb(ctrl_q, wdata, wstrb)
                & ~word_t'(2);
      if (wr_en && wr_idx == A_WIDTH)
        width_q <= apply_strb(width_q, wdata, wstrb);
      if (wr_en && wr_idx == A_COUNT)
        count_q <= apply_strb(count_q, wdata, wstrb);
      if (wr_en && wr_idx == A_GAP)
        gap_q <= apply_strb(gap_q, wdata, wstrb);
      // a new event wins over a same-cycle clear
      if (set_done)
        done_q <= 1'b1;
      else if (wr_stat && b0 && wdata[1])
        done_q <= 1'b0;
      if (fault_in)
        fault_q <= 1'b1;
      else if (wr_stat && b0 && wdata[2])
        fault_q <= 1'b0;
    end
  end

  // ---------------- read channel ----------------
  logic  ar_rdy_q, r_vld_q;
  word_t rdata_q, rd_mux;
  idx_t  rd_idx;

  assign rd_idx = s_axi.S_AXI_ARADDR[AW-1:2];

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (rd_idx == A_CTRL):   rd_mux = ctrl_q;
      (rd_idx == A_WIDTH):  rd_mux = width_q;
      (rd_idx == A_COUNT):  rd_mux = count_q;
      (rd_idx == A_GAP):    rd_mux = gap_q;
      (rd_idx == A_STATUS):
        rd_mux = {{(DW-3){1'b0}}, fault_q, done_q, busy};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ar_rdy_q <= 1'b0;
      r_vld_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ar_rdy_q <= s_axi.S_AXI_ARVALID & ~r_vld_q & ~ar_rdy_q;
      if (ar_rdy_q && s_axi.S_AXI_ARVALID) begin
        r_vld_q <= 1'b1;
        rdata_q <= rd_mux;
      end else if (s_axi.S_AXI_RREADY) begin
        r_vld_q <= 1'b0;
      end
    end
  end

  assign s_axi.S_AXI_ARREADY = ar_rdy_q;
  assign s_axi.S_AXI_RVALID  = r_vld_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0],
                       s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_pulse_ctrl_axil_slave.sv
// Bench for pulse_ctrl_axil_slave: AXI-Lite register access,
// pulse trains, fault/abort and handshake ordering.
module tb_pulse_ctrl_axil_slave;

  logic clk = 1'b0;
  logic rst;
  logic fault_in;
  logic pulse_out;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd_q[$];
  logic        pulse_log[$];
  bit          rec_en = 1'b0;

  always #5 clk = ~clk;

  pulse_ctrl_axil_slave_if #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5)
  ) bus ();

  pulse_ctrl_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5)
  ) dut (
    .ACLK     (clk),
    .ARESET   (rst),
    .s_axi    (bus),
    .fault_in (fault_in),
    .pulse_out(pulse_out),
    .busy     (busy)
  );

  always @(negedge clk)
    if (rec_en) pulse_log.push_back(pulse_out);

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0]  addr,
                           input logic [31:0] data,
                           input logic [3:0]  strb,
                           input bit          rec);
    int t;
    @(negedge clk);
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    t = 0;
    while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      check("aw_timeout", 32'd1, 32'd0);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    if (rec) begin
      pulse_log.delete();
      rec_en = 1'b1;
    end
    t = 0;
    @(negedge clk);
    while (!bus.S_AXI_BVALID && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("b_timeout", 32'd1, 32'd0);
    else check("bresp", 32'(bus.S_AXI_BRESP), 32'd0);
    @(posedge clk);
    #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0]  addr,
                          input logic [31:0] exp,
                          input string       tag);
    int t;
    logic [31:0] e;
    rd_q.push_back(exp);
    @(negedge clk);
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    t = 0;
    while (!bus.S_AXI_ARREADY && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t < 20) begin
      @(posedge clk);
      #1;
    end
    bus.S_AXI_ARVALID = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.S_AXI_RVALID && t < 20) begin
      @(negedge clk);
      t++;
    end
    e = rd_q.pop_front();
    if (t >= 20) begin
      check({tag, "_timeout"}, 32'd1, 32'd0);
    end else begin
      check({tag, "_rresp"}, 32'(bus.S_AXI_RRESP), 32'd0);
      check(tag, bus.S_AXI_RDATA, e);
    end
    @(posedge clk);
    #1;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  logic exp_train [12] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    int acc;
    int bcnt;
    int t;
    rst      = 1'b1;
    fault_in = 1'b0;
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWPROT  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARPROT  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_outs",
          32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
               bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
               bus.S_AXI_RVALID, pulse_out, busy}), 32'd0);
    check("rst_rdata", bus.S_AXI_RDATA, 32'd0);
    axi_read(5'h00, 32'h0, "rst_ctrl");
    axi_read(5'h10, 32'h0, "rst_status");

    // basic R/W
    axi_write(5'h00, 32'h1, 4'hF, 1'b0);
    axi_write(5'h04, 32'h2, 4'hF, 1'b0);
    axi_write(5'h08, 32'h3, 4'hF, 1'b0);
    axi_write(5'h0C, 32'h4, 4'hF, 1'b0);
    axi_read(5'h00, 32'h1, "rd_ctrl");
    axi_read(5'h04, 32'h2, "rd_width");
    axi_read(5'h08, 32'h3, "rd_count");
    axi_read(5'h0C, 32'h4, "rd_gap");
    axi_read(5'h14, 32'h0, "rd_unmapped");
    axi_read(5'h07, 32'h2, "rd_lowbits");
    check("no_pulse", 32'(pulse_out), 32'd0);

    // byte strobes
    axi_write(5'h04, 32'hAABBCCDD, 4'b0010, 1'b0);
    axi_read(5'h04, 32'h0000CC02, "rd_wstrb");

    // train 3/2/2
    axi_write(5'h04, 32'd3, 4'hF, 1'b0);
    axi_write(5'h08, 32'd2, 4'hF, 1'b0);
    axi_write(5'h0C, 32'd2, 4'hF, 1'b0);
    axi_write(5'h00, 32'h3, 4'hF, 1'b1);
    repeat (12) @(negedge clk);
    rec_en = 1'b0;
    check("train_len_ok", 32'(pulse_log.size() >= 12), 32'd1);
    for (int i = 0; i < 12 && i < pulse_log.size(); i++)
      check($sformatf("train_p%0d", i),
            32'(pulse_log[i]), 32'(exp_train[i]));
    axi_read(5'h10, 32'h2, "train_status");
    axi_read(5'h00, 32'h1, "ctrl_fire_rd0");
    axi_write(5'h10, 32'h2, 4'hF, 1'b0);
    axi_read(5'h10, 32'h0, "status_w1c");

    // COUNT = 0
    axi_write(5'h08, 32'd0, 4'hF, 1'b0);
    axi_write(5'h00, 32'h3, 4'hF, 1'b1);
    repeat (3) @(negedge clk);
    rec_en = 1'b0;
    acc = 0;
    foreach (pulse_log[i]) if (pulse_log[i]) acc++;
    check("cnt0_nopulse", 32'(acc), 32'd0);
    axi_read(5'h10, 32'h2, "cnt0_status");
    axi_write(5'h10, 32'h6, 4'hF, 1'b0);

    // fault during a long pulse
    axi_write(5'h04, 32'd100, 4'hF, 1'b0);
    axi_write(5'h08, 32'd1, 4'hF, 1'b0);
    axi_write(5'h00, 32'h3, 4'hF, 1'b0);
    repeat (2) @(negedge clk);
    check("flt_pre", 32'({pulse_out, busy}), 32'd3);
    fault_in = 1'b1;
    @(negedge clk);
    fault_in = 1'b0;
    check("flt_post", 32'({pulse_out, busy}), 32'd0);
    axi_read(5'h10, 32'h4, "flt_status");
    axi_write(5'h10, 32'h4, 4'hF, 1'b0);
    axi_read(5'h10, 32'h0, "flt_clear");

    // abort by clearing EN
    axi_write(5'h00, 32'h3, 4'hF, 1'b0);
    @(negedge clk);
    check("abt_pre", 32'({pulse_out, busy}), 32'd3);
    axi_write(5'h00, 32'h0, 4'hF, 1'b0);
    check("abt_post", 32'({pulse_out, busy}), 32'd0);
    axi_read(5'h10, 32'h0, "abt_status");

    // AW ahead of W, slow B
    @(negedge clk);
    bus.S_AXI_AWADDR  = 5'h0C;
    bus.S_AXI_WDATA   = 32'h55;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.S_AXI_AWREADY) acc++;
    end
    check("aw_early_rdy", 32'(acc), 32'd0);
    bus.S_AXI_WVALID = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.S_AXI_AWREADY && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("aw_early_hs", 32'(t < 20), 32'd1);
    @(posedge clk);
    #1;
    bus.S_AXI_AWADDR = 5'h04;
    bus.S_AXI_WDATA  = 32'h77;
    acc  = 0;
    bcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.S_AXI_AWREADY) acc++;
      if (bus.S_AXI_BVALID) bcnt++;
    end
    check("b_hold", 32'(bcnt), 32'd4);
    check("aw_blocked", 32'(acc), 32'd0);
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk);
    #1;
    bus.S_AXI_BREADY = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.S_AXI_AWREADY && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("aw2_hs", 32'(t < 20), 32'd1);
    @(posedge clk);
    #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    @(negedge clk);
    check("b2_valid", 32'(bus.S_AXI_BVALID), 32'd1);
    @(posedge clk);
    #1;
    bus.S_AXI_BREADY = 1'b0;
    axi_read(5'h0C, 32'h55, "aw_early_gap");
    axi_read(5'h04, 32'h77, "aw2_width");

    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
